// File: rtl/measure_seq.sv
// measure_seq: gate/settle/capture sequencer for the multi-phase duty-cycle counter,
// presenting duty, gate and edge counts on a valid/lock handshake.
module measure_seq #(
  parameter int CNT_WIDTH  = 32,
  parameter int CLR_CYC    = 4,
  parameter int SETTLE_CYC = 4,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont,
  input  logic [CNT_WIDTH-1:0] gate_len,
  input  logic                 sig_in,
  input  logic [CNT_WIDTH-1:0] duty_cnt_in,
  output logic                 meas_rst,
  output logic                 real_gate,
  output logic [CNT_WIDTH-1:0] duty_cnt,
  output logic [CNT_WIDTH-1:0] gate_cnt,
  output logic [CNT_WIDTH-1:0] edge_cnt,
  output logic                 cnt_valid,
  input  logic                 cnt_lock,
  output logic                 busy,
  output logic                 timeout
);
  typedef enum logic [2:0] {IDLE, CLEAR, ARM, GATE, CLOSE, SETTLE, CAPTURE, VALID} state_t;

  localparam logic [CNT_WIDTH-1:0] TO_LIM = CNT_WIDTH'(TIMEOUT);
  localparam logic [3:0] CLR_LAST = 4'(CLR_CYC - 1);
  localparam logic [3:0] SET_LAST = 4'(SETTLE_CYC - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] x);
    return &x ? x : x + CNT_WIDTH'(1);
  endfunction

  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [3:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] gcnt_q, gcnt_d, ecnt_q, ecnt_d, ptim_q, ptim_d, wtim_q, wtim_d;
  logic [CNT_WIDTH-1:0] glen, wtim_inc;
  logic to_q, to_d, rise;
  logic meas_rst_q, real_gate_q, busy_q, valid_q;
  logic [CNT_WIDTH-1:0] duty_q, gate_q, edge_q;

  assign rise     = sync_q[1] & ~sync_q[2];
  assign glen     = (gate_len == '0) ? CNT_WIDTH'(1) : gate_len;
  assign wtim_inc = sat_inc(wtim_q);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 4'd1;
    gcnt_d  = gcnt_q;
    ecnt_d  = ecnt_q;
    ptim_d  = ptim_q;
    wtim_d  = wtim_q;
    to_d    = to_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CLEAR;
        to_d    = 1'b0;
      end
      CLEAR: begin
        gcnt_d  = '0;
        ecnt_d  = '0;
        ptim_d  = '0;
        wtim_d  = '0;
        state_d = (cyc_q == CLR_LAST) ? ARM : CLEAR;
      end
      ARM: begin
        wtim_d = wtim_inc;
        if (rise) state_d = GATE;
        else if (wtim_inc >= TO_LIM) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
      GATE: begin
        gcnt_d = sat_inc(gcnt_q);
        ecnt_d = rise ? sat_inc(ecnt_q) : ecnt_q;
        ptim_d = sat_inc(ptim_q);
        if (ptim_d >= glen) begin
          state_d = CLOSE;
          wtim_d  = '0;
        end
      end
      CLOSE: begin
        gcnt_d = sat_inc(gcnt_q);
        wtim_d = wtim_inc;
        if (rise) begin
          ecnt_d  = sat_inc(ecnt_q);
          state_d = SETTLE;
        end else if (wtim_inc >= TO_LIM) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end
      end
      SETTLE:  state_d = (cyc_q == SET_LAST) ? CAPTURE : SETTLE;
      CAPTURE: state_d = VALID;
      VALID:   if (cnt_lock) state_d = cont ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
    // per-state cycle counter restarts on every state entry
    if (state_d != state_q) cyc_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      cyc_q       <= '0;
      gcnt_q      <= '0;
      ecnt_q      <= '0;
      ptim_q      <= '0;
      wtim_q      <= '0;
      to_q        <= 1'b0;
      meas_rst_q  <= 1'b0;
      real_gate_q <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      duty_q      <= '0;
      gate_q      <= '0;
      edge_q      <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[1:0], sig_in};
      cyc_q       <= cyc_d;
      gcnt_q      <= gcnt_d;
      ecnt_q      <= ecnt_d;
      ptim_q      <= ptim_d;
      wtim_q      <= wtim_d;
      to_q        <= to_d;
      meas_rst_q  <= state_d == CLEAR;
      real_gate_q <= state_d inside {GATE, CLOSE};
      busy_q      <= state_d != IDLE;
      valid_q     <= state_d == VALID;
      if (state_q == CAPTURE) begin
        duty_q <= duty_cnt_in;
        gate_q <= gcnt_q;
        edge_q <= ecnt_q;
      end
    end
  end

  assign meas_rst  = meas_rst_q;
  assign real_gate = real_gate_q;
  assign busy      = busy_q;
  assign cnt_valid = valid_q;
  assign timeout   = to_q;
  assign duty_cnt  = duty_q;
  assign gate_cnt  = gate_q;
  assign edge_cnt  = edge_q;
endmodule

// File: tb/tb_measure_seq.sv
// tb_measure_seq: directed checks of measure_seq with a simple phase-counter model
// that counts clk cycles where real_gate and sig_in are both high.
module tb_measure_seq;
  localparam int W = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0, sig_in = 1'b0, cnt_lock = 1'b0;
  logic meas_rst, real_gate, cnt_valid, busy, timeout;
  logic [W-1:0] gate_len = '0, duty_cnt_in, duty_cnt, gate_cnt, edge_cnt;
  logic [W-1:0] mdl = '0;
  logic sig_en = 1'b0;
  int per = 10, hi = 3, ph = 0;
  int n_cmp = 0, n_err = 0;
  int rg_tot = 0, mr_tot = 0, busy_tot = 0, val_tot = 0;
  int rg0, mr0, busy0, val0;
  int dly [3] = '{0, 5, 20};

  always #5 clk = ~clk;

  measure_seq #(.CNT_WIDTH(W), .CLR_CYC(4), .SETTLE_CYC(4), .TIMEOUT(50)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .gate_len(gate_len),
    .sig_in(sig_in), .duty_cnt_in(duty_cnt_in), .meas_rst(meas_rst), .real_gate(real_gate),
    .duty_cnt(duty_cnt), .gate_cnt(gate_cnt), .edge_cnt(edge_cnt), .cnt_valid(cnt_valid),
    .cnt_lock(cnt_lock), .busy(busy), .timeout(timeout)
  );

  assign duty_cnt_in = mdl;
  always @(posedge clk) mdl <= meas_rst ? '0 : (real_gate && sig_in) ? mdl + 1 : mdl;

  always @(negedge clk) begin
    if (!sig_en) begin
      ph = 0;
      sig_in = 1'b0;
    end else begin
      ph = (ph >= per - 1) ? 0 : ph + 1;
      sig_in = (ph < hi);
    end
  end

  always @(negedge clk) begin
    rg_tot   += int'(real_gate);
    mr_tot   += int'(meas_rst);
    busy_tot += int'(busy);
    val_tot  += int'(cnt_valid);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_lock();
    cnt_lock = 1'b1;
    @(negedge clk) cnt_lock = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (cnt_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk(tag, W'(cnt_valid), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    chk(tag, W'(busy), 0);
  endtask

  task automatic wait_gate(input string tag);
    int n = 0;
    while (real_gate !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk(tag, W'(real_gate), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_meas_rst", W'(meas_rst), 0);
    chk("rst_real_gate", W'(real_gate), 0);
    chk("rst_valid", W'(cnt_valid), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_timeout", W'(timeout), 0);
    chk("rst_duty", duty_cnt, 0);
    chk("rst_gate", gate_cnt, 0);
    chk("rst_edge", edge_cnt, 0);
    rst_n = 1'b1;

    // single measurement: gate 100, period 10, high 3
    gate_len = 100; per = 10; hi = 3; sig_en = 1'b1;
    repeat (3) @(negedge clk);
    rg0 = rg_tot; mr0 = mr_tot;
    pulse_start();
    wait_valid("t1_valid_wait");
    chk("t1_gate_cnt", gate_cnt, 110);
    chk("t1_edge_cnt", edge_cnt, 11);
    chk("t1_duty_cnt", duty_cnt, 33);
    chk("t1_gate_span", W'(rg_tot - rg0), 110);
    chk("t1_meas_rst_len", W'(mr_tot - mr0), 4);
    chk("t1_timeout", W'(timeout), 0);
    repeat (3) @(negedge clk);
    chk("t1_valid_held", W'(cnt_valid), 1);
    chk("t1_gate_held", gate_cnt, 110);
    do_lock();
    chk("t1_valid_drop", W'(cnt_valid), 0);
    chk("t1_idle", W'(busy), 0);

    // no signal: ARM times out
    sig_en = 1'b0;
    repeat (5) @(negedge clk);
    busy0 = busy_tot; mr0 = mr_tot; val0 = val_tot; rg0 = rg_tot;
    pulse_start();
    wait_idle("t2_idle_wait");
    chk("t2_busy_len", W'(busy_tot - busy0), 54);
    chk("t2_meas_rst_len", W'(mr_tot - mr0), 4);
    chk("t2_no_valid", W'(val_tot - val0), 0);
    chk("t2_no_gate", W'(rg_tot - rg0), 0);
    chk("t2_timeout", W'(timeout), 1);

    // continuous mode, three handshakes with varied lock delay
    cont = 1'b1; gate_len = 20; sig_en = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    chk("t3_timeout_clr", W'(timeout), 0);
    for (int i = 0; i < 3; i++) begin
      wait_valid($sformatf("t3_valid_wait%0d", i));
      chk($sformatf("t3_gate%0d", i), gate_cnt, 30);
      chk($sformatf("t3_edge%0d", i), edge_cnt, 3);
      chk($sformatf("t3_duty%0d", i), duty_cnt, 9);
      repeat (dly[i]) @(negedge clk);
      chk($sformatf("t3_valid_held%0d", i), W'(cnt_valid), 1);
      chk($sformatf("t3_duty_held%0d", i), duty_cnt, 9);
      if (i == 2) cont = 1'b0;
      do_lock();
      chk($sformatf("t3_valid_drop%0d", i), W'(cnt_valid), 0);
      chk($sformatf("t3_clear_after%0d", i), W'(meas_rst), (i < 2) ? 1 : 0);
    end
    chk("t3_idle", W'(busy), 0);

    // start during GATE and VALID is ignored
    mr0 = mr_tot;
    pulse_start();
    wait_gate("t4_gate_wait");
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_valid("t4_valid_wait");
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_valid_held", W'(cnt_valid), 1);
    chk("t4_gate_cnt", gate_cnt, 30);
    start = 1'b0;
    do_lock();
    chk("t4_idle", W'(busy), 0);
    chk("t4_one_clear", W'(mr_tot - mr0), 4);

    // asynchronous reset mid-GATE
    gate_len = 100;
    pulse_start();
    wait_gate("t5_gate_wait");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_real_gate", W'(real_gate), 0);
    chk("t5_busy", W'(busy), 0);
    chk("t5_gate_cnt", gate_cnt, 0);
    chk("t5_edge_cnt", edge_cnt, 0);
    chk("t5_duty_cnt", duty_cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // gate_len 0 behaves as 1, period 4 high 2
    gate_len = 0; per = 4; hi = 2;
    repeat (3) @(negedge clk);
    pulse_start();
    wait_valid("t6_valid_wait");
    chk("t6_gate_cnt", gate_cnt, 4);
    chk("t6_edge_cnt", edge_cnt, 1);
    chk("t6_duty_cnt", duty_cnt, 2);
    chk("t6_timeout", W'(timeout), 0);
    do_lock();
    chk("t6_valid_drop", W'(cnt_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/measure_seq.md
Name: measure_seq

Overview:
- Sequencer for the duty-cycle/frequency measurement datapath.
- Clears the measurement counters, opens a preset gate and then a signal-aligned real gate, and waits for the multi-phase counters to settle.
- Captures the counter result plus its own reference-clock and edge counts, then presents them on a valid/lock handshake.
- Sits between the control register block and the 4-phase duty counter.

Parameters:
- CNT_WIDTH, 32, width of all count/data buses
- CLR_CYC, 4, cycles meas_rst is held high in CLEAR (1..15)
- SETTLE_CYC, 4, cycles waited after real_gate falls before capture (1..15)
- TIMEOUT, 1000000, max cycles waiting for a sig_in rising edge in ARM or while closing the gate

Ports:
- clk  in  1  system/reference clock (0-degree phase)
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; sampled in IDLE only
- cont  in  1  continuous mode: re-arm after each handshake
- gate_len  in  CNT_WIDTH  preset gate length in clk cycles; 0 is treated as 1
- sig_in  in  1  measured signal, asynchronous
- duty_cnt_in  in  CNT_WIDTH  summed duty count from the phase counters
- meas_rst  out  1  active-high clear to the phase counters
- real_gate  out  1  signal-aligned gate to the phase counters
- duty_cnt  out  CNT_WIDTH  captured duty count
- gate_cnt  out  CNT_WIDTH  captured clk cycles during real_gate
- edge_cnt  out  CNT_WIDTH  captured sig_in rising edges during real_gate
- cnt_valid  out  1  result available
- cnt_lock  in  1  consumer acknowledge
- busy  out  1  state != IDLE
- timeout  out  1  sticky; last run aborted for lack of signal

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. All outputs 0, including the captured registers and timeout.
- sig_in handling:
  - Two-flop synchroniser, then a third flop.
  - rise = sync2 & ~sync3.
  - All edge decisions use rise, so latency from a sig_in edge to a rise decision is 2–3 cycles.
- States: IDLE, CLEAR, ARM, GATE, CLOSE, SETTLE, CAPTURE, VALID. All outputs are registered.
- IDLE:
  - start=1 -> CLEAR; clear timeout.
  - start is ignored in every other state.
- CLEAR:
  - meas_rst=1 for exactly CLR_CYC cycles.
  - Internal gate_cnt, edge_cnt, preset timer and wait timer are zeroed.
  - Then -> ARM.
- ARM:
  - Wait timer counts.
  - rise -> GATE; real_gate goes 1 on the first GATE cycle.
  - Wait timer reaching TIMEOUT -> IDLE with timeout=1. No capture, cnt_valid stays 0.
- GATE:
  - real_gate=1; gate_cnt +1 per cycle; edge_cnt +1 per rise (the opening edge is not counted).
  - Preset timer +1 per cycle.
  - When the timer reaches max(gate_len,1) -> CLOSE. The wait timer is restarted.
- CLOSE:
  - real_gate stays 1; gate_cnt keeps counting.
  - The next rise increments edge_cnt and -> SETTLE. real_gate drops on the first SETTLE cycle.
  - Result: edge_cnt = whole signal periods; gate_cnt = their duration in clk cycles.
  - Wait timer reaching TIMEOUT -> IDLE with timeout=1. real_gate drops.
- SETTLE:
  - real_gate=0 for SETTLE_CYC cycles, so the phase counters finish their last increment.
  - Then -> CAPTURE.
- CAPTURE: one cycle; duty_cnt<=duty_cnt_in; gate_cnt/edge_cnt outputs <= internal counts; -> VALID.
- VALID handshake:
  - cnt_valid=1 and the outputs are held stable.
  - On a cycle with cnt_lock=1: cnt_valid=0 next cycle; -> CLEAR if cont=1, else IDLE.
  - cnt_lock while not VALID is ignored.
  - Captured outputs retain their value until the next CAPTURE.
- Arithmetic: internal counters saturate at all-ones (no wrap). Timers are CNT_WIDTH bits.
- Simultaneous events:
  - rise on the same cycle the preset timer expires in GATE: the rise counts in GATE, then CLOSE waits for the next rise.
  - gate_len changes mid-run: the new value is used from the next comparison onward; software must change it only in IDLE.
- rst_n asserted mid-operation: immediate return to IDLE, all outputs 0. A pending result is lost.

Test Plan:
- gate_len=100, sig_in period 10 cycles, high 3, bench phase-counter model:
  - -> real_gate spans ≥100 cycles, closes on a sig rise.
  - -> gate_cnt=110, edge_cnt=11 (integer multiple of 10).
  - -> duty_cnt equals the model's value; cnt_valid=1 until cnt_lock.
- sig_in held 0, start=1, TIMEOUT=50 -> IDLE after 50 ARM cycles, timeout=1, cnt_valid never asserts, meas_rst pulse exactly CLR_CYC cycles.
- cont=1, three consecutive handshakes, with cnt_lock delayed 0, 5 and 20 cycles -> three captures; outputs stable while valid; CLEAR follows each lock.
- gate_len=0, period 4 -> behaves as gate_len=1: gate_cnt=4 and edge_cnt=1, or gate_cnt=8 and edge_cnt=2 when a rise coincides with timer expiry.
- rst_n low for 1 cycle during GATE -> all outputs 0 asynchronously; a subsequent start runs a clean measurement.
- start held high and pulsed during GATE/VALID -> no restart; only the IDLE sample launches a run.
